conv_window_stream: RTL and testbench

Streaming 3x3 convolution window generator between the host DMA word stream and the convolution array. It accepts one control word, forwards a configurable number of weight words, then rasters one channel lane of an NxN image through a two-line buffer. It emits one 3x3 window per output position, with valid/ready backpressure on both sides and an end-of-frame pulse. It generalises the earlier fixed-geometry frame slider with parametrised width, lane count, maximum image width and weight count, plus optional zero padding.

---
 rtl/conv_window_stream.sv | 189 ++++++++++++++++++
 tb/tb_conv_window_stream.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_stream.sv
// rtl/conv_window_stream.sv - streaming 3x3 window generator; optional zero border under `ZERO_PAD_EN
module conv_window_stream #(
    parameter int DATA_W       = 16,
    parameter int LANES        = 4,
    parameter int MAX_W        = 416,
    parameter int WEIGHT_WORDS = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [9*DATA_W-1:0]     m_data,
    output logic                    m_kind,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    o_done,
    output logic                    o_err
);
    localparam int OUT_W = 9 * DATA_W;
`ifdef ZERO_PAD_EN
    localparam int DEPTH = MAX_W + 1;
`else
    localparam int DEPTH = MAX_W;
`endif
    localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] MAX_N  = 11'(MAX_W);
    localparam logic [15:0] W_LAST = 16'(WEIGHT_WORDS - 1);

    typedef enum logic [1:0] {
        S_CTRL,
        S_WEIGHT,
`ifdef ZERO_PAD_EN
        S_IMAGE,
        S_DRAIN
`else
        S_IMAGE
`endif
    } state_t;

    state_t          state;
    logic [9:0]      n_reg;
    logic [1:0]      lane_reg;
    logic [9:0]      row;
    logic [9:0]      col;
    logic [15:0]     wcnt;
    logic            m_last;

    logic [DATA_W-1:0]   line0 [0:DEPTH-1];
    logic [DATA_W-1:0]   line1 [0:DEPTH-1];
    logic [3*DATA_W-1:0] tap_a;
    logic [3*DATA_W-1:0] tap_b;

    logic                out_free, virt, accept, step, emit, last_col, last_pos;
    logic [9:0]          ctrl_n;
    logic [1:0]          ctrl_lane;
    logic                ctrl_bad;
    logic [AW-1:0]       addr;
    logic [DATA_W-1:0]   pixel;
    logic [3*DATA_W-1:0] raw_col, win_a, win_b, win_c;
    logic [OUT_W-1:0]    window;

    // Handshake, scan-position decode and window assembly for the current cycle
    always_comb begin
        ctrl_n    = s_data[11:2];
        ctrl_lane = 2'(32'(s_data[1:0]) % LANES);
        ctrl_bad  = (ctrl_n < 10'd3) || ({1'b0, ctrl_n} > MAX_N);
        out_free  = !m_valid || m_ready;
`ifdef ZERO_PAD_EN
        virt      = (state == S_DRAIN) || ((state == S_IMAGE) && (col == n_reg));
        last_col  = (col == n_reg);
        last_pos  = (state == S_DRAIN) && last_col;
        emit      = (row != 10'd0) && (col != 10'd0);
`else
        virt      = 1'b0;
        last_col  = (col == n_reg - 10'd1);
        last_pos  = last_col && (row == n_reg - 10'd1);
        emit      = (row >= 10'd2) && (col >= 10'd2);
`endif
        s_ready   = out_free && !virt;
        accept    = s_valid && s_ready;
        step      = virt ? out_free : ((state == S_IMAGE) && accept);
        addr      = col[AW-1:0];
        pixel     = virt ? '0 : s_data[32'(lane_reg)*DATA_W +: DATA_W];
        raw_col   = {line1[addr], line0[addr], pixel};
        win_a     = tap_a;
        win_b     = tap_b;
        win_c     = raw_col;
`ifdef ZERO_PAD_EN
        // Border taps: row -1 on the first output row, column -1 on the first output column
        if (row == 10'd1) begin
            win_a[3*DATA_W-1 -: DATA_W] = '0;
            win_b[3*DATA_W-1 -: DATA_W] = '0;
            win_c[3*DATA_W-1 -: DATA_W] = '0;
        end
        if (col == 10'd1) begin
            win_a = '0;
        end
`endif
        window = {win_a[3*DATA_W-1 -: DATA_W], win_b[3*DATA_W-1 -: DATA_W], win_c[3*DATA_W-1 -: DATA_W],
                  win_a[2*DATA_W-1 -: DATA_W], win_b[2*DATA_W-1 -: DATA_W], win_c[2*DATA_W-1 -: DATA_W],
                  win_a[DATA_W-1:0],           win_b[DATA_W-1:0],           win_c[DATA_W-1:0]};
    end

    // Line buffers and tap columns advance once per scan position
    always_ff @(posedge clk) begin
        if (step) begin
            line1[addr] <= line0[addr];
            line0[addr] <= pixel;
            tap_a       <= tap_b;
            tap_b       <= raw_col;
        end
    end

    // Frame FSM with the registered output stage and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CTRL;
            n_reg    <= '0;
            lane_reg <= '0;
            row      <= '0;
            col      <= '0;
            wcnt     <= '0;
            m_valid  <= 1'b0;
            m_kind   <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_done <= m_valid && m_ready && m_last;
            o_err  <= 1'b0;
            if (out_free) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            case (state)
                S_CTRL: begin
                    if (accept) begin
                        if (ctrl_bad) begin
                            o_err <= 1'b1;
                        end else begin
                            n_reg    <= ctrl_n;
                            lane_reg <= ctrl_lane;
                            row      <= '0;
                            col      <= '0;
                            wcnt     <= '0;
                            state    <= (WEIGHT_WORDS == 0) ? S_IMAGE : S_WEIGHT;
                        end
                    end
                end
                S_WEIGHT: begin
                    if (accept) begin
                        m_valid <= 1'b1;
                        m_kind  <= 1'b0;
                        m_data  <= OUT_W'(s_data);
                        wcnt    <= wcnt + 16'd1;
                        if (wcnt == W_LAST) begin
                            state <= S_IMAGE;
                        end
                    end
                end
                default: begin
                    if (step) begin
                        if (emit) begin
                            m_valid <= 1'b1;
                            m_kind  <= 1'b1;
                            m_data  <= window;
                            m_last  <= last_pos;
                        end
                        if (last_pos) begin
                            state <= S_CTRL;
                        end else if (last_col) begin
                            col <= '0;
                            row <= row + 10'd1;
`ifdef ZERO_PAD_EN
                            if (row == n_reg - 10'd1) begin
                                state <= S_DRAIN;
                            end
`endif
                        end else begin
                            col <= col + 10'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_stream.sv
// tb/tb_conv_window_stream.sv - scoreboard bench for conv_window_stream
module tb_conv_window_stream;
    localparam int DATA_W = 16;
    localparam int LANES = 4;
    localparam int MAX_W = 416;
    localparam int WEIGHT_WORDS = 9;
    localparam int IN_W = LANES * DATA_W;
    localparam int OUT_W = 9 * DATA_W;
`ifdef ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  s_data;
    logic             s_valid;
    logic             s_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_kind;
    logic             m_valid;
    logic             m_ready;
    logic             o_done;
    logic             o_err;

    conv_window_stream #(
        .DATA_W(DATA_W), .LANES(LANES), .MAX_W(MAX_W), .WEIGHT_WORDS(WEIGHT_WORDS)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_kind(m_kind), .m_valid(m_valid), .m_ready(m_ready),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [OUT_W:0]    sb[$];
    int                done_cnt = 0;
    int                err_cnt = 0;
    int                win_cnt = 0;
    int                ready_low = 0;
    bit                bp_en = 1'b0;
    logic [DATA_W-1:0] img [0:15][0:15];
    bit                stall_prev = 1'b0;
    logic [OUT_W:0]    held;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] exp_win(input int y, input int x, input int n);
        logic [OUT_W-1:0] d = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                int rr;
                int cc;
                rr = y - 1 + dy;
                cc = x - 1 + dx;
                d = d << DATA_W;
                if (rr >= 0 && rr < n && cc >= 0 && cc < n) d[DATA_W-1:0] = img[rr][cc];
            end
        end
        return d;
    endfunction

    // Output monitor: scoreboard compare, hold-while-stalled, event counters
    always @(negedge clk) begin
        logic [OUT_W:0] e;
        if (!rst) begin
            if (stall_prev) begin
                check_eq("hold_valid", m_valid, 1);
                check_eq("hold_data", {m_kind, m_data}, held);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    if (e[OUT_W]) check_eq("window", {m_kind, m_data}, e);
                    else check_eq("weight", {m_kind, m_data}, e);
                end
                if (m_kind) win_cnt++;
            end
            if (o_done) begin
                done_cnt++;
                check_eq("done_sb_empty", sb.size(), 0);
            end
            if (o_err) err_cnt++;
            if (!s_ready) ready_low++;
        end
        stall_prev = m_valid && !m_ready && !rst;
        held = {m_kind, m_data};
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_en ? ($urandom_range(0, 99) >= 40) : 1'b1;
        end
    end

    task automatic send_word(input logic [IN_W-1:0] w);
        bit ok;
        int t;
        s_data = w;
        s_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            t++;
            if (t > 500) begin
                check_eq("send_timeout", t, 0);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic run_frame(input int n, input int lane, input bit lane_tag, input int abort_after);
        logic [IN_W-1:0] w;
        logic [IN_W-1:0] wt;
        int d0, w0, sent, t, lo, hi;
        bit stop;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                img[r][c] = lane_tag ? 16'((lane + 1) * 4096 + r * n + c + 1) : 16'(r * n + c + 1);
        d0 = done_cnt;
        w0 = win_cnt;
        send_word({$urandom(), 20'($urandom()), 10'(n), 2'(lane)});
        for (int i = 0; i < WEIGHT_WORDS; i++) begin
            wt = {$urandom(), $urandom()};
            sb.push_back({1'b0, OUT_W'(wt)});
            send_word(wt);
        end
        lo = PAD ? 0 : 1;
        hi = PAD ? n - 1 : n - 2;
        for (int y = lo; y <= hi; y++)
            for (int x = lo; x <= hi; x++)
                sb.push_back({1'b1, exp_win(y, x, n)});
        sent = 0;
        stop = 1'b0;
        for (int r = 0; r < n && !stop; r++) begin
            for (int c = 0; c < n && !stop; c++) begin
                for (int k = 0; k < LANES; k++) begin
                    if (lane_tag) w[k*DATA_W +: DATA_W] = 16'((k + 1) * 4096 + r * n + c + 1);
                    else if (k == lane) w[k*DATA_W +: DATA_W] = img[r][c];
                    else w[k*DATA_W +: DATA_W] = 16'($urandom());
                end
                send_word(w);
                sent++;
                if (sent == abort_after) stop = 1'b1;
            end
        end
        if (!stop) begin
            t = 0;
            while (done_cnt == d0 && t < 400) begin
                @(posedge clk);
                #1;
                t++;
            end
            check_eq("frame_done", done_cnt - d0, 1);
            repeat (3) @(posedge clk);
            #1;
            check_eq("done_once", done_cnt - d0, 1);
            check_eq("win_count", win_cnt - w0, (hi - lo + 1) * (hi - lo + 1));
        end
    endtask

    initial begin
        int d0;
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_kind", m_kind, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_o_done", o_done, 0);
        check_eq("rst_o_err", o_err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_s_ready", s_ready, 1);

        // Basic frame N=4, lane 0; s_ready only drops on virtual positions
        ready_low = 0;
        run_frame(4, 0, 1'b0, -1);
        check_eq("ready_low_n4", ready_low, PAD ? 9 : 0);

        // Pad geometry frame N=3: 3 virtual columns + 4 drain cycles when padded
        ready_low = 0;
        run_frame(3, 0, 1'b0, -1);
        check_eq("ready_low_n3", ready_low, PAD ? 7 : 0);

        // Lane select: every lane carries a tagged value, only lane 2 may appear
        run_frame(4, 2, 1'b1, -1);

        // Backpressure on the output side
        bp_en = 1'b1;
        run_frame(5, 1, 1'b0, -1);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Bad control words: N=2 and N=MAX_W+1
        d0 = err_cnt;
        send_word({52'h0, 10'd2, 2'd0});
        check_eq("err_n2", o_err, 1);
        send_word({52'h0, 10'(MAX_W + 1), 2'd0});
        check_eq("err_nmax", o_err, 1);
        @(posedge clk);
        #1;
        check_eq("err_pulse", o_err, 0);
        check_eq("err_count", err_cnt - d0, 2);
        run_frame(3, 3, 1'b0, -1);

        // Reset after 5 pixels of an N=4 frame
        d0 = done_cnt;
        run_frame(4, 1, 1'b0, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_m_valid", m_valid, 0);
        check_eq("mid_rst_m_kind", m_kind, 0);
        check_eq("mid_rst_m_data", m_data, 0);
        check_eq("mid_rst_o_done", o_done, 0);
        rst = 1'b0;
        sb.delete();
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_rst_no_done", done_cnt - d0, 0);
        run_frame(4, 0, 1'b0, -1);

        check_eq("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
